// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the IF/LS memory bus arbiter.
// Owner and state encodings are used by the top and the winner picker.
package MemArbPkg;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LS
    } arb_owner_e;

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Combinational winner select for the memory bus arbiter.
// LS wins by default; a raised starve flag hands the slot to a waiting IF.
module mem_arb_pick
    import MemArbPkg::*;
(
    input  logic       if_req_i,
    input  logic       ls_req_i,
    input  logic       starve_i,
    output arb_owner_e owner_o
);

    always_comb begin
        owner_o = OWN_NONE;
        if (if_req_i && starve_i) begin
            owner_o = OWN_IF;
        end else if (ls_req_i) begin
            owner_o = OWN_LS;
        end else if (if_req_i) begin
            owner_o = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// Define ARB_STARVE_GUARD_EN to force an IF grant after STARVE_LIMIT back-to-back LS grants.
module mem_bus_arbiter
    import MemArbPkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_strb,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_strb,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;

    arb_owner_e          win;
    logic                starve;
    logic                idle;

    assign idle = (state_q == IDLE);

    mem_arb_pick u_pick (
        .if_req_i (if_req),
        .ls_req_i (ls_req),
        .starve_i (starve),
        .owner_o  (win)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign starve = if_req && (starve_q == CNT_W'(STARVE_LIMIT));

    // Counts LS grants that left a requesting IF waiting.
    always_comb begin
        starve_d = starve_q;
        if (idle && win == OWN_IF) begin
            starve_d = '0;
        end else if (idle && win == OWN_LS) begin
            starve_d = if_req ? starve_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_limit;

    assign unused_limit = ^STARVE_LIMIT;
    assign starve       = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        ls_gnt    = 1'b0;
        ls_rvalid = 1'b0;
        ls_rdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_strb  = '0;
        unique case (state_q)
            IDLE: begin
                if (win == OWN_LS) begin
                    ls_gnt  = 1'b1;
                    owner_d = OWN_LS;
                    we_d    = ls_we;
                    addr_d  = ls_addr;
                    wdata_d = ls_we ? ls_wdata : '0;
                    strb_d  = ls_we ? ls_strb : '0;
                    state_d = REQ;
                end else if (win == OWN_IF) begin
                    if_gnt  = 1'b1;
                    owner_d = OWN_IF;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    strb_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_strb  = strb_q;
                if (mem_gnt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // Response is forwarded in the same cycle it arrives.
                if (mem_rvalid) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                    if (owner_q == OWN_IF) begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end else if (owner_q == OWN_LS) begin
                        ls_rvalid = 1'b1;
                        ls_rdata  = we_q ? '0 : mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
        end
    end

endmodule
